// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared definitions for the MEM pipeline stage: datapath and
//                register-address widths, funct3 load/store encodings, FSM
//                state encodings and the store byte-strobe helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    // Datapath / register-address widths
    localparam int c_XLEN    = 32;
    localparam int c_RADDR_W = 5;

    // funct3 access size / sign encodings
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // Bus FSM states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    // Byte strobes for a store; funct3[1:0] carries the size.
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << a;
            2'b01:   s = 4'b0011 << {a[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data alignment. Selects the addressed
//                byte/half lane of the read word and sign- or zero-extends it.
//  Ports       : rdata  in  XLEN  raw word from data memory
//                a      in  2     low address bits of the access
//                funct3 in  3     access size / sign
//                result out XLEN  aligned, extended load value
//  Revision    : 1.0  initial release
// ============================================================================
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      a,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] w_lane;

    assign w_lane = rdata >> {a, 3'b000};

    always_comb begin
        case (funct3)
            c_F3_B:  result = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            c_F3_H:  result = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            c_F3_BU: result = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            c_F3_HU: result = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            default: result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Passes ALU results straight through,
//                runs loads/stores on the req/gnt/rvalid data bus, aligns
//                load data and stalls IF/ID/EX until each access completes.
//  Ports       : clk, rstn (sync, active-low)
//                EX_*        EX-stage results (held by the stall)
//                dmem_*      data-memory request/response bus
//                MEM_*       values for the MEM/WB register
//                mem_stall   freeze upstream stages this cycle
//                mem_misalign (only with MEM_MISALIGN_TRAP_EN defined)
//  Options     : MEM_MISALIGN_TRAP_EN - misaligned half/word accesses are
//                not issued; mem_misalign pulses and the write is squashed.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = c_XLEN,
    parameter int RADDR_W = c_RADDR_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               EX_valid,
    input  logic [XLEN-1:0]    EX_result,
    input  logic [XLEN-1:0]    EX_wdata,
    input  logic [2:0]         EX_funct3,
    input  logic [RADDR_W-1:0] EX_rd_addr,
    input  logic               EX_rmem,
    input  logic               EX_wmem,
    input  logic               EX_wen,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_addr,
    output logic [3:0]         dmem_wstrb,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [XLEN-1:0]    MEM_result,
    output logic [RADDR_W-1:0] MEM_rd_addr,
    output logic               MEM_rmem,
    output logic               MEM_wen,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic               mem_misalign,
`endif
    output logic               mem_stall
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [1:0]      r_a;
    logic [2:0]      r_f3;

    logic            w_is_mem;
    logic            w_misalign;
    logic            w_idle_issue;
    logic [XLEN-1:0] w_ex_addr;
    logic [3:0]      w_ex_wstrb;
    logic [XLEN-1:0] w_ex_wdata;
    logic            w_active;
    logic            w_done;
    logic            w_cur_we;
    logic [1:0]      w_cur_a;
    logic [2:0]      w_cur_f3;
    logic [1:0]      w_next;
    logic [XLEN-1:0] w_aligned;

    // Memory ops are suppressed while reset is asserted so a held request
    // is dropped immediately rather than at the next edge.
    assign w_is_mem = rstn & EX_valid & (EX_rmem | EX_wmem);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = w_is_mem & (r_state == c_ST_IDLE) &
                        (((EX_funct3[1:0] == 2'b01) & EX_result[0]) |
                         ((EX_funct3[1:0] == 2'b10) & (|EX_result[1:0])));
    assign mem_misalign = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_idle_issue = (r_state == c_ST_IDLE) & w_is_mem & ~w_misalign;

    assign w_ex_addr  = {EX_result[XLEN-1:2], 2'b00};
    assign w_ex_wstrb = store_strobe(EX_funct3, EX_result[1:0]);

    always_comb begin
        case (EX_funct3[1:0])
            2'b00:   w_ex_wdata = {(XLEN/8){EX_wdata[7:0]}};
            2'b01:   w_ex_wdata = {(XLEN/16){EX_wdata[15:0]}};
            default: w_ex_wdata = EX_wdata;
        endcase
    end

    // In IDLE the request is driven straight from EX; once the request is
    // pending, the captured copy keeps the bus fields stable until gnt.
    always_comb begin
        w_active = 1'b0;
        w_done   = 1'b0;
        w_next   = r_state;
        dmem_req = 1'b0;
        w_cur_we = r_we;
        w_cur_a  = r_a;
        w_cur_f3 = r_f3;
        case (r_state)
            c_ST_IDLE: begin
                w_cur_we = EX_wmem;
                w_cur_a  = EX_result[1:0];
                w_cur_f3 = EX_funct3;
                w_active = w_idle_issue;
                dmem_req = w_idle_issue;
                // A load whose rvalid comes with its gnt completes at once.
                w_done   = w_idle_issue & dmem_gnt & (EX_wmem | dmem_rvalid);
                if (w_idle_issue) begin
                    if (!dmem_gnt)
                        w_next = c_ST_REQ;
                    else if (!EX_wmem && !dmem_rvalid)
                        w_next = c_ST_WAIT;
                    else
                        w_next = c_ST_IDLE;
                end
            end
            c_ST_REQ: begin
                w_active = 1'b1;
                dmem_req = 1'b1;
                w_done   = dmem_gnt & (r_we | dmem_rvalid);
                if (!dmem_gnt)
                    w_next = c_ST_REQ;
                else if (!r_we && !dmem_rvalid)
                    w_next = c_ST_WAIT;
                else
                    w_next = c_ST_IDLE;
            end
            c_ST_WAIT: begin
                w_active = 1'b1;
                w_done   = dmem_rvalid;
                w_next   = dmem_rvalid ? c_ST_IDLE : c_ST_WAIT;
            end
            default: w_next = c_ST_IDLE;
        endcase
        if (!rstn) begin
            dmem_req = 1'b0;
            w_active = 1'b0;
        end
    end

    assign dmem_we    = w_cur_we;
    assign dmem_addr  = (r_state == c_ST_IDLE) ? w_ex_addr  : r_addr;
    assign dmem_wstrb = (r_state == c_ST_IDLE) ? w_ex_wstrb : r_wstrb;
    assign dmem_wdata = (r_state == c_ST_IDLE) ? w_ex_wdata : r_wdata;
    assign mem_stall  = w_active & ~w_done;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem_rdata),
        .a      (w_cur_a),
        .funct3 (w_cur_f3),
        .result (w_aligned)
    );

    assign MEM_result  = (w_done & ~w_cur_we) ? w_aligned : EX_result;
    assign MEM_rd_addr = EX_rd_addr;
    assign MEM_rmem    = EX_valid & EX_rmem & ~mem_stall & ~w_misalign;
    assign MEM_wen     = EX_valid & EX_wen  & ~mem_stall & ~w_misalign;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_wdata <= '0;
            r_a     <= 2'b00;
            r_f3    <= 3'b000;
        end else begin
            r_state <= w_next;
            // Capture continuously while idle; the value present on the
            // issue cycle is the one that survives into REQ/WAIT.
            if (r_state == c_ST_IDLE) begin
                r_addr  <= w_ex_addr;
                r_we    <= EX_wmem;
                r_wstrb <= w_ex_wstrb;
                r_wdata <= w_ex_wdata;
                r_a     <= EX_result[1:0];
                r_f3    <= EX_funct3;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Retiring instructions
//                are checked by a scoreboard monitor; bus and stall
//                behaviour is checked cycle by cycle by the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    localparam int c_XLEN    = 32;
    localparam int c_RADDR_W = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        EX_valid;
    logic [31:0] EX_result;
    logic [31:0] EX_wdata;
    logic [2:0]  EX_funct3;
    logic [4:0]  EX_rd_addr;
    logic        EX_rmem, EX_wmem, EX_wen;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] MEM_result;
    logic [4:0]  MEM_rd_addr;
    logic        MEM_rmem, MEM_wen;
    logic        mem_stall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_misalign;
`endif

    always #5 clk = ~clk;

    mem_stage #(.XLEN(c_XLEN), .RADDR_W(c_RADDR_W)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .EX_valid    (EX_valid),
        .EX_result   (EX_result),
        .EX_wdata    (EX_wdata),
        .EX_funct3   (EX_funct3),
        .EX_rd_addr  (EX_rd_addr),
        .EX_rmem     (EX_rmem),
        .EX_wmem     (EX_wmem),
        .EX_wen      (EX_wen),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .MEM_result  (MEM_result),
        .MEM_rd_addr (MEM_rd_addr),
        .MEM_rmem    (MEM_rmem),
        .MEM_wen     (MEM_wen),
`ifdef MEM_MISALIGN_TRAP_EN
        .mem_misalign(mem_misalign),
`endif
        .mem_stall   (mem_stall)
    );

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rmem;
    } ret_t;

    ret_t r_exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every retirement pops one expected entry.
    always @(negedge clk) begin
        ret_t e;
        if (MEM_wen === 1'b1) begin
            if (r_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL ret_unexpected: got rd=%0d result=%h expected no retirement",
                         MEM_rd_addr, MEM_result);
            end else begin
                e = r_exp_q.pop_front();
                chk("ret_result", MEM_result, e.result);
                chk("ret_rd", {27'd0, MEM_rd_addr}, {27'd0, e.rd});
                chk("ret_rmem", {31'd0, MEM_rmem}, {31'd0, e.rmem});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [31:0] res, input logic [31:0] wd,
                      input logic [2:0] f3, input logic [4:0] rd,
                      input logic rm, input logic wm, input logic we);
        EX_valid = v;   EX_result = res; EX_wdata = wd; EX_funct3 = f3;
        EX_rd_addr = rd; EX_rmem = rm;   EX_wmem = wm;  EX_wen = we;
    endtask

    task automatic bus(input logic g, input logic rv, input logic [31:0] rd);
        dmem_gnt = g; dmem_rvalid = rv; dmem_rdata = rd;
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic rm);
        ret_t e;
        e.result = res; e.rd = rd; e.rmem = rm;
        r_exp_q.push_back(e);
    endtask

    initial begin
        rstn = 1'b0;
        ex(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        bus(1'b0, 1'b0, 32'h0);
        step(); step();
        @(negedge clk);
        chk("reset_stall", {31'd0, mem_stall}, 32'd0);
        chk("reset_req", {31'd0, dmem_req}, 32'd0);
        chk("reset_wen", {31'd0, MEM_wen}, 32'd0);

        // ADD passes straight through
        step();
        rstn = 1'b1;
        ex(1'b1, 32'h1234, 32'h0, 3'b000, 5'd5, 1'b0, 1'b0, 1'b1);
        push(32'h1234, 5'd5, 1'b0);
        @(negedge clk);
        chk("add_stall", {31'd0, mem_stall}, 32'd0);
        chk("add_req", {31'd0, dmem_req}, 32'd0);
        chk("add_result", MEM_result, 32'h1234);

        // LB @0x103: issue, gnt next cycle, rvalid the cycle after
        step();
        ex(1'b1, 32'h103, 32'h0, 3'b000, 5'd6, 1'b1, 1'b0, 1'b1);
        push(32'hFFFF_FF80, 5'd6, 1'b1);
        @(negedge clk);
        chk("lb_c0_stall", {31'd0, mem_stall}, 32'd1);
        chk("lb_c0_req", {31'd0, dmem_req}, 32'd1);
        chk("lb_c0_addr", dmem_addr, 32'h100);
        chk("lb_c0_we", {31'd0, dmem_we}, 32'd0);
        chk("lb_c0_wen", {31'd0, MEM_wen}, 32'd0);
        step();
        bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lb_c1_stall", {31'd0, mem_stall}, 32'd1);
        chk("lb_c1_req", {31'd0, dmem_req}, 32'd1);
        step();
        bus(1'b0, 1'b1, 32'h80FF_0000);
        @(negedge clk);
        chk("lb_c2_stall", {31'd0, mem_stall}, 32'd0);
        chk("lb_c2_req", {31'd0, dmem_req}, 32'd0);
        chk("lb_c2_wen", {31'd0, MEM_wen}, 32'd1);

        // SH @0x102, gnt held off for three cycles
        step();
        bus(1'b0, 1'b0, 32'h0);
        ex(1'b1, 32'h102, 32'h0000_BEEF, 3'b001, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sh_stall", {31'd0, mem_stall}, 32'd1);
            chk("sh_req", {31'd0, dmem_req}, 32'd1);
            chk("sh_we", {31'd0, dmem_we}, 32'd1);
            chk("sh_addr", dmem_addr, 32'h100);
            chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
            chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
            step();
        end
        bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("sh_gnt_stall", {31'd0, mem_stall}, 32'd0);
        chk("sh_gnt_req", {31'd0, dmem_req}, 32'd1);
        chk("sh_gnt_wstrb", {28'd0, dmem_wstrb}, 32'hC);

        // LHU @0x100 with gnt and rvalid together: no stall
        step();
        ex(1'b1, 32'h100, 32'h0, 3'b101, 5'd7, 1'b1, 1'b0, 1'b1);
        bus(1'b1, 1'b1, 32'h0000_8001);
        push(32'h0000_8001, 5'd7, 1'b1);
        @(negedge clk);
        chk("lhu_stall", {31'd0, mem_stall}, 32'd0);
        chk("lhu_wen", {31'd0, MEM_wen}, 32'd1);

        // SW back-to-back @0x104, immediate gnt
        step();
        ex(1'b1, 32'h104, 32'hCAFE_BABE, 3'b010, 5'd0, 1'b0, 1'b1, 1'b0);
        bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("sw_stall", {31'd0, mem_stall}, 32'd0);
        chk("sw_addr", dmem_addr, 32'h104);
        chk("sw_wstrb", {28'd0, dmem_wstrb}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFE_BABE);

        // SB @0x101
        step();
        ex(1'b1, 32'h101, 32'h1234_56A5, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);

        // LBU @0x101, zero-extended
        step();
        ex(1'b1, 32'h101, 32'h0, 3'b100, 5'd8, 1'b1, 1'b0, 1'b1);
        bus(1'b1, 1'b1, 32'h1234_80AB);
        push(32'h0000_0080, 5'd8, 1'b1);
        @(negedge clk);
        chk("lbu_stall", {31'd0, mem_stall}, 32'd0);

        // LH @0x102: gnt then rvalid, sign-extended upper half
        step();
        ex(1'b1, 32'h102, 32'h0, 3'b001, 5'd10, 1'b1, 1'b0, 1'b1);
        bus(1'b1, 1'b0, 32'h0);
        push(32'hFFFF_8001, 5'd10, 1'b1);
        @(negedge clk);
        chk("lh_c0_stall", {31'd0, mem_stall}, 32'd1);
        step();
        bus(1'b0, 1'b1, 32'h8001_0000);
        @(negedge clk);
        chk("lh_c1_stall", {31'd0, mem_stall}, 32'd0);
        chk("lh_c1_req", {31'd0, dmem_req}, 32'd0);

        // Stray rvalid in IDLE does not disturb a plain ALU op
        step();
        ex(1'b1, 32'h55, 32'h0, 3'b000, 5'd3, 1'b0, 1'b0, 1'b1);
        bus(1'b0, 1'b1, 32'hFFFF_FFFF);
        push(32'h55, 5'd3, 1'b0);
        @(negedge clk);
        chk("stray_stall", {31'd0, mem_stall}, 32'd0);
        chk("stray_result", MEM_result, 32'h55);

        // Reset while waiting for rvalid
        step();
        ex(1'b1, 32'h200, 32'h0, 3'b010, 5'd9, 1'b1, 1'b0, 1'b1);
        bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_wait_stall", {31'd0, mem_stall}, 32'd1);
        step();
        rstn = 1'b0;
        ex(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        step();
        rstn = 1'b1;
        bus(1'b0, 1'b1, 32'h0000_DEAD);
        @(negedge clk);
        chk("rst_late_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_late_wen", {31'd0, MEM_wen}, 32'd0);
        chk("rst_late_req", {31'd0, dmem_req}, 32'd0);
        step();
        bus(1'b0, 1'b0, 32'h0);
        ex(1'b1, 32'h77, 32'h0, 3'b000, 5'd4, 1'b0, 1'b0, 1'b1);
        push(32'h77, 5'd4, 1'b0);
        @(negedge clk);
        chk("post_rst_stall", {31'd0, mem_stall}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        // LW @0x102 traps instead of issuing
        step();
        ex(1'b1, 32'h102, 32'h0, 3'b010, 5'd11, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_flag", {31'd0, mem_misalign}, 32'd1);
        chk("mis_wen", {31'd0, MEM_wen}, 32'd0);
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
`endif

        step();
        ex(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("queue_empty", r_exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
